// File: rtl/stream_arbiter_unit.sv
// Per-output round-robin arbiter for the stream crossbar. Each output picks one
// requesting slave and holds it until the packet's last beat is accepted.
module stream_arbiter_unit #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  input  logic [M_DATA_COUNT-1:0]                    m_valid_i,
  input  logic [M_DATA_COUNT-1:0]                    m_last_i,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_o,
  output logic [M_DATA_COUNT-1:0]                    arbiter_ready_o,
  output logic [S_DATA_COUNT-1:0]                    busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
  logic [M_DATA_COUNT-1:0][0:0]              state_q, state_d;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_d;
  logic [S_DATA_COUNT-1:0]                   busy_d;

  // A slave already locked elsewhere is hidden from every output.
  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      for (int k = 0; k < S_DATA_COUNT; k++) begin
        req[j][k] = s_valid_i[k] && (s_dest_i[k] == T_DEST_WIDTH'(j)) && !busy_o[k];
      end
    end
  end

  always_comb begin : next_state
    int idx;
    // NOTE: every comb output gets a default up front so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_o;
    idx     = 0;
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      case (state_q[j])
        ST_IDLE: begin
          // Walk the search order backwards so the last hit is the first in rr order.
          for (int i = S_DATA_COUNT; i >= 1; i--) begin
            idx = (int'(ptr_q[j]) + i) % S_DATA_COUNT;
            if (req[j][idx]) begin
              grant_d[j] = T_ID___WIDTH'(idx);
              ptr_d[j]   = T_ID___WIDTH'(idx);
              state_d[j] = ST_LOCKED;
            end
          end
        end
        default: begin
          if (m_valid_i[j] && m_ready_i[j] && m_last_i[j]) state_d[j] = ST_IDLE;
        end
      endcase
    end
  end

  // busy_o is registered from the next-state lock map so it tracks the FSMs exactly.
  always_comb begin
    busy_d = '0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        if (state_d[j] == ST_LOCKED && grant_d[j] == T_ID___WIDTH'(k)) busy_d[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= '0;
      grant_o <= '0;
      busy_o  <= '0;
      for (int j = 0; j < M_DATA_COUNT; j++) ptr_q[j] <= T_ID___WIDTH'(S_DATA_COUNT - 1);
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      busy_o  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) arbiter_ready_o[j] = (state_q[j] == ST_LOCKED);
  end

endmodule

// File: tb/tb_stream_arbiter_unit.sv
// Directed bench for stream_arbiter_unit (2 slaves, 3 outputs): a vector table
// plus hand-written sequences for back-pressure and asynchronous reset.
module tb_stream_arbiter_unit;

  logic             clk_i = 1'b0;
  logic             rst_in;
  logic [1:0][1:0]  s_dest_i;
  logic [1:0]       s_valid_i;
  logic [2:0]       m_valid_i, m_last_i, m_ready_i;
  logic [2:0][0:0]  grant_o;
  logic [2:0]       arbiter_ready_o;
  logic [1:0]       busy_o;

  int n_checks = 0;
  int n_errors = 0;

  stream_arbiter_unit #(.S_DATA_COUNT(2), .M_DATA_COUNT(3)) dut (
    .clk_i           (clk_i),
    .rst_in          (rst_in),
    .s_dest_i        (s_dest_i),
    .s_valid_i       (s_valid_i),
    .m_valid_i       (m_valid_i),
    .m_last_i        (m_last_i),
    .m_ready_i       (m_ready_i),
    .grant_o         (grant_o),
    .arbiter_ready_o (arbiter_ready_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] d0, d1;
    logic [1:0] sv;
    logic [2:0] mv, ml, mr;
    logic [2:0] eg;
    logic [2:0] er;
    logic [1:0] eb;
  } vec_t;

  localparam int N_VEC = 19;
  vec_t tbl [N_VEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] sv,
                       input logic [2:0] mv, input logic [2:0] ml, input logic [2:0] mr);
    s_dest_i  = {d1, d0};
    s_valid_i = sv;
    m_valid_i = mv;
    m_last_i  = ml;
    m_ready_i = mr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] eg, input logic [2:0] er,
                           input logic [1:0] eb);
    check({tag, ".grant"}, 8'(grant_o), 8'(eg));
    check({tag, ".ready"}, 8'(arbiter_ready_o), 8'(er));
    check({tag, ".busy"},  8'(busy_o), 8'(eb));
  endtask

  initial begin
    //            d0    d1    sv     mv      ml      mr      eg      er      eb
    tbl[0]  = '{2'd0, 2'd0, 2'b00, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00}; // idle
    tbl[1]  = '{2'd2, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 2'b01}; // s0->o2
    tbl[2]  = '{2'd2, 2'd0, 2'b01, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 2'b01}; // mid beat
    tbl[3]  = '{2'd2, 2'd0, 2'b00, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 2'b00}; // last
    tbl[4]  = '{2'd0, 2'd2, 2'b11, 3'b000, 3'b000, 3'b000, 3'b100, 3'b101, 2'b11}; // dual
    tbl[5]  = '{2'd0, 2'd2, 2'b00, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000, 2'b00}; // both rel
    tbl[6]  = '{2'd1, 2'd1, 2'b11, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 2'b01}; // rr: s0
    tbl[7]  = '{2'd1, 2'd1, 2'b11, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000, 2'b00}; // release
    tbl[8]  = '{2'd1, 2'd1, 2'b11, 3'b000, 3'b000, 3'b000, 3'b110, 3'b010, 2'b10}; // rr: s1
    tbl[9]  = '{2'd1, 2'd1, 2'b11, 3'b010, 3'b010, 3'b010, 3'b110, 3'b000, 2'b00}; // release
    tbl[10] = '{2'd1, 2'd1, 2'b11, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 2'b01}; // wrap: s0
    tbl[11] = '{2'd1, 2'd1, 2'b11, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000, 2'b00}; // release
    tbl[12] = '{2'd0, 2'd0, 2'b00, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 2'b00}; // idle
    tbl[13] = '{2'd3, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 2'b00}; // dest 3
    tbl[14] = '{2'd3, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 2'b00};
    tbl[15] = '{2'd3, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 2'b00};
    tbl[16] = '{2'd0, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 2'b01}; // s0->o0
    tbl[17] = '{2'd2, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 2'b01}; // dest moves
    tbl[18] = '{2'd2, 2'd0, 2'b00, 3'b001, 3'b001, 3'b001, 3'b100, 3'b000, 2'b00}; // release

    rst_in = 1'b0;
    drive(2'd0, 2'd0, 2'b00, 3'b000, 3'b000, 3'b000);
    repeat (2) tick();
    check_all("reset", 3'b000, 3'b000, 2'b00);
    rst_in = 1'b1;
    tick();

    for (int i = 0; i < N_VEC; i++) begin
      drive(tbl[i].d0, tbl[i].d1, tbl[i].sv, tbl[i].mv, tbl[i].ml, tbl[i].mr);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].er, tbl[i].eb);
    end

    // Back-pressure on a last beat while the locked slave withdraws its request.
    drive(2'd0, 2'd1, 2'b10, 3'b000, 3'b000, 3'b000);
    tick();
    check_all("bp.lock", 3'b110, 3'b010, 2'b10);
    drive(2'd0, 2'd1, 2'b00, 3'b010, 3'b010, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("bp.hold%0d", i), 3'b110, 3'b010, 2'b10);
    end
    m_ready_i = 3'b010;
    tick();
    check_all("bp.release", 3'b110, 3'b000, 2'b00);
    drive(2'd0, 2'd1, 2'b00, 3'b000, 3'b000, 3'b000);
    tick();
    check_all("bp.idle", 3'b110, 3'b000, 2'b00);

    // Asynchronous reset in the middle of a locked packet.
    drive(2'd0, 2'd0, 2'b01, 3'b000, 3'b000, 3'b000);
    tick();
    check_all("ar.lock", 3'b110, 3'b001, 2'b01);
    #2 rst_in = 1'b0;
    #1 check_all("ar.async", 3'b000, 3'b000, 2'b00);
    drive(2'd0, 2'd0, 2'b00, 3'b000, 3'b000, 3'b000);
    #2 rst_in = 1'b1;
    tick();
    check_all("ar.idle", 3'b000, 3'b000, 2'b00);
    // Pointer must be back at S-1: slave 0 wins on output 0.
    drive(2'd0, 2'd0, 2'b11, 3'b000, 3'b000, 3'b000);
    tick();
    check_all("ar.ptr", 3'b000, 3'b001, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
